// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard bundle: the ID instruction's register usage in, and stall/forward controls out.
// The master side is the decode stage; the slave side is the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_rwd;
  logic             id_wr;
  logic             id_load;
  logic             stall;
  logic             bubble;
  logic [2:0]       rs_fwd;
  logic [2:0]       rt_fwd;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rwd, id_wr, id_load,
    input  stall, bubble, rs_fwd, rt_fwd, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rwd, id_wr, id_load,
    output stall, bubble, rs_fwd, rt_fwd, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: EX/MEM/WB destination scoreboard, registered operand
// forwarding selects, one-cycle load-use stall and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned CNT_W     = 16,
  parameter bit          WB_BYPASS = 1'b1
) (
  input logic           clk,
  input logic           rst,
  hazard_ctrl_if.slave  bus
);

  logic             r_ex_v,  r_mem_v,  r_wb_v;
  logic [REG_W-1:0] r_ex_rwd, r_mem_rwd, r_wb_rwd;
  logic             r_ex_ld, r_mem_ld;
  logic [2:0]       r_rs_fwd, r_rt_fwd;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_ex_rs, w_mem_rs, w_wb_rs;
  logic       w_ex_rt, w_mem_rt, w_wb_rt;
  logic       w_stall;
  logic [2:0] w_rs_fwd, w_rt_fwd;

  // Register 0 is hard-wired and never produces a match.
  always_comb begin
    w_ex_rs  = bus.id_use_rs && r_ex_v  && (r_ex_rwd  != '0) && (r_ex_rwd  == bus.id_rs);
    w_mem_rs = bus.id_use_rs && r_mem_v && (r_mem_rwd != '0) && (r_mem_rwd == bus.id_rs);
    w_wb_rs  = bus.id_use_rs && r_wb_v  && (r_wb_rwd  != '0) && (r_wb_rwd  == bus.id_rs);
    w_ex_rt  = bus.id_use_rt && r_ex_v  && (r_ex_rwd  != '0) && (r_ex_rwd  == bus.id_rt);
    w_mem_rt = bus.id_use_rt && r_mem_v && (r_mem_rwd != '0) && (r_mem_rwd == bus.id_rt);
    w_wb_rt  = bus.id_use_rt && r_wb_v  && (r_wb_rwd  != '0) && (r_wb_rwd  == bus.id_rt);
    w_stall  = bus.id_valid && r_ex_ld && (w_ex_rs || w_ex_rt);
  end

  // Nearest producer wins; an EX match here is always an ALU result since loads stall.
  always_comb begin
    w_rs_fwd = 3'd0;
    w_rt_fwd = 3'd0;
    if (bus.id_valid && !w_stall) begin
      if (w_ex_rs)                  w_rs_fwd = 3'd1;
      else if (w_mem_rs)            w_rs_fwd = r_mem_ld ? 3'd3 : 3'd2;
      else if (w_wb_rs && WB_BYPASS) w_rs_fwd = 3'd4;

      if (w_ex_rt)                  w_rt_fwd = 3'd1;
      else if (w_mem_rt)            w_rt_fwd = r_mem_ld ? 3'd3 : 3'd2;
      else if (w_wb_rt && WB_BYPASS) w_rt_fwd = 3'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_v      <= 1'b0;
      r_ex_rwd    <= '0;
      r_ex_ld     <= 1'b0;
      r_mem_v     <= 1'b0;
      r_mem_rwd   <= '0;
      r_mem_ld    <= 1'b0;
      r_wb_v      <= 1'b0;
      r_wb_rwd    <= '0;
      r_rs_fwd    <= 3'd0;
      r_rt_fwd    <= 3'd0;
      r_stall_cnt <= '0;
    end else begin
      r_wb_v    <= r_mem_v;
      r_wb_rwd  <= r_mem_rwd;
      r_mem_v   <= r_ex_v;
      r_mem_rwd <= r_ex_rwd;
      r_mem_ld  <= r_ex_ld;
      // A stalled ID instruction enters EX as an invalid entry: the bubble.
      r_ex_v    <= bus.id_valid && bus.id_wr && !w_stall;
      r_ex_rwd  <= bus.id_rwd;
      r_ex_ld   <= bus.id_load && bus.id_valid && !w_stall;
      r_rs_fwd  <= w_rs_fwd;
      r_rt_fwd  <= w_rt_fwd;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall     = w_stall;
  assign bus.bubble    = w_stall;
  assign bus.rs_fwd    = r_rs_fwd;
  assign bus.rt_fwd    = r_rt_fwd;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
